// File: rtl/bwt_mem_req_arbiter_if.sv
// Memory request bus between the lane arbiter and the BWT occurrence memory/cache port.
interface bwt_mem_req_arbiter_if #(
    parameter int ADDR_W = 42,
    parameter int LANE_W = 2,
    parameter int RN_W   = 10
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LANE_W-1:0] mem_req_lane;
    logic [RN_W-1:0]   mem_req_rn;
    logic              mem_req_kl;
    logic              mem_req_both;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_lane, mem_req_rn, mem_req_kl, mem_req_both,
        input  mem_req_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_lane, mem_req_rn, mem_req_kl, mem_req_both,
        output mem_req_ready
    );
endinterface

// File: rtl/bwt_mem_req_arbiter.sv
// Round-robin arbiter sharing one BWT occurrence memory request port between
// backward-extension lanes; issues k then l line beats, merged when they coincide.
module bwt_mem_req_arbiter #(
    parameter int N_LANE = 4,
    parameter int LANE_W = 2,
    parameter int ADDR_W = 42,
    parameter int RN_W   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_LANE-1:0]        lane_req_valid,
    input  logic [N_LANE*ADDR_W-1:0] lane_addr_k,
    input  logic [N_LANE*ADDR_W-1:0] lane_addr_l,
    input  logic [N_LANE*RN_W-1:0]   lane_read_num,
    output logic [N_LANE-1:0]        lane_stall,
    bwt_mem_req_arbiter_if.master    mem,
    output logic [31:0]              beat_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_K = 2'd1,
        ISSUE_L = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [LANE_W-1:0] last;
    logic [ADDR_W-1:0] cap_l;

    logic              q_valid, q_kl, q_both;
    logic [ADDR_W-1:0] q_addr;
    logic [LANE_W-1:0] q_lane;
    logic [RN_W-1:0]   q_rn;

    logic              n_valid, n_kl, n_both;
    logic [ADDR_W-1:0] n_addr;
    logic [LANE_W-1:0] n_lane;
    logic [RN_W-1:0]   n_rn;
    logic              load_cap;

    logic              grant_found;
    logic [LANE_W-1:0] grant, idx;
    logic [ADDR_W-1:0] sel_k, sel_l;
    logic [RN_W-1:0]   sel_rn;
    logic              last_beat;
    logic [N_LANE-1:0] done;

    // Search starts just past the last granted lane so every lane gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int unsigned i = 1; i <= N_LANE; i++) begin
            idx = LANE_W'(32'(last) + i);
            if (!grant_found && lane_req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        sel_k  = '0;
        sel_l  = '0;
        sel_rn = '0;
        for (int unsigned i = 0; i < N_LANE; i++) begin
            if (grant == LANE_W'(i)) begin
                sel_k  = lane_addr_k[i*ADDR_W +: ADDR_W];
                sel_l  = lane_addr_l[i*ADDR_W +: ADDR_W];
                sel_rn = lane_read_num[i*RN_W +: RN_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        n_valid   = q_valid;
        n_addr    = q_addr;
        n_lane    = q_lane;
        n_rn      = q_rn;
        n_kl      = q_kl;
        n_both    = q_both;
        load_cap  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    state_nxt = ISSUE_K;
                    load_cap  = 1'b1;
                    n_valid   = 1'b1;
                    n_addr    = sel_k;
                    n_lane    = grant;
                    n_rn      = sel_rn;
                    n_kl      = 1'b0;
                    n_both    = (sel_k == sel_l);
                end
            end
            ISSUE_K: begin
                if (mem.mem_req_ready) begin
                    if (q_both) begin
                        state_nxt = IDLE;
                        n_valid   = 1'b0;
                        n_addr    = '0;
                        n_lane    = '0;
                        n_rn      = '0;
                        n_kl      = 1'b0;
                        n_both    = 1'b0;
                    end else begin
                        state_nxt = ISSUE_L;
                        n_addr    = cap_l;
                        n_kl      = 1'b1;
                        n_both    = 1'b0;
                    end
                end
            end
            ISSUE_L: begin
                if (mem.mem_req_ready) begin
                    state_nxt = IDLE;
                    n_valid   = 1'b0;
                    n_addr    = '0;
                    n_lane    = '0;
                    n_rn      = '0;
                    n_kl      = 1'b0;
                    n_both    = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                n_valid   = 1'b0;
                n_addr    = '0;
                n_lane    = '0;
                n_rn      = '0;
                n_kl      = 1'b0;
                n_both    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_valid    <= 1'b0;
            q_addr     <= '0;
            q_lane     <= '0;
            q_rn       <= '0;
            q_kl       <= 1'b0;
            q_both     <= 1'b0;
            cap_l      <= '0;
            last       <= LANE_W'(N_LANE - 1);
            beat_count <= '0;
        end else begin
            q_valid <= n_valid;
            q_addr  <= n_addr;
            q_lane  <= n_lane;
            q_rn    <= n_rn;
            q_kl    <= n_kl;
            q_both  <= n_both;
            if (load_cap) begin
                cap_l <= sel_l;
                last  <= grant;
            end
            if (q_valid && mem.mem_req_ready) begin
                beat_count <= beat_count + 32'd1;
            end
        end
    end

    // A reset edge discards the in-flight beat, so the lane must not be released on it.
    assign last_beat = rst && mem.mem_req_ready &&
                       (((state == ISSUE_K) && q_both) || (state == ISSUE_L));

    always_comb begin
        done = '0;
        for (int unsigned i = 0; i < N_LANE; i++) begin
            done[i] = last_beat && (q_lane == LANE_W'(i));
        end
    end

    assign lane_stall = lane_req_valid & ~done;

    assign mem.mem_req_valid = q_valid;
    assign mem.mem_req_addr  = q_addr;
    assign mem.mem_req_lane  = q_lane;
    assign mem.mem_req_rn    = q_rn;
    assign mem.mem_req_kl    = q_kl;
    assign mem.mem_req_both  = q_both;

endmodule
